// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: shares the single-port data memory and the switch/LED
// registers between the CPU load/store path and the UART program loader.
// Each access runs IDLE -> ACCESS (-> RESP for reads) -> IDLE.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie-break instead of
// fixed loader priority).
module mem_io_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-11:0] IO_BASE   = 22'h3FFFFF,
    parameter logic [7:0]            LED_OFS    = 8'h60,
    parameter logic [7:0]            SW_OFS     = 8'h70
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_stall,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [15:0]           switch,
    output logic [15:0]           led
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // owner encoding: 0 = CPU, 1 = loader
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]           led_q, led_d;
    logic [15:0]           sw_q, sw_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_owner_q, last_owner_d;
`endif

    logic                  grant_ldr;
    logic                  is_io;
    logic                  done;
    logic [DATA_WIDTH-1:0] resp_data;

    // Decode the latched address and select the read-response source.
    always_comb begin
        is_io     = (addr_q[ADDR_WIDTH-1:10] == IO_BASE);
        resp_data = mem_rdata;
        if (is_io) begin
            if (addr_q[7:0] == SW_OFS)
                resp_data = {{(DATA_WIDTH-16){1'b0}}, sw_q};
            else
                resp_data = '0;
        end
    end

    // Arbitration, next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        led_d       = led_q;
        sw_d        = sw_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        mem_we      = 1'b0;
        done        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        // On a tie the requester that did not own the bus last time wins.
        grant_ldr    = ldr_req && (!cpu_req || !last_owner_q);
`else
        grant_ldr    = ldr_req;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
                    owner_d = grant_ldr;
                    we_d    = grant_ldr ? ldr_we    : cpu_we;
                    addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
                    wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
                    state_d = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = grant_ldr;
`endif
                end
            end
            S_ACCESS: begin
                mem_we = we_q && !is_io;
                sw_d   = switch;
                if (we_q && is_io && (addr_q[7:0] == LED_OFS))
                    led_d = wdata_q[15:0];
                if (we_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done = 1'b1;
                if (owner_q) ldr_rdata_d = resp_data;
                else         cpu_rdata_d = resp_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            led_q       <= '0;
            sw_q        <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            led_q       <= led_d;
            sw_q        <= sw_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the most recent grant; reset to CPU so the loader wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_owner_q <= 1'b0;
        else      last_owner_q <= last_owner_d;
    end
`endif

    // Response outputs: read data passes straight through during RESP, then is held.
    always_comb begin
        cpu_done  = done && !owner_q;
        ldr_done  = done &&  owner_q;
        cpu_rdata = (state_q == S_RESP && !owner_q) ? resp_data : cpu_rdata_q;
        ldr_rdata = (state_q == S_RESP &&  owner_q) ? resp_data : ldr_rdata_q;
        cpu_stall = cpu_req && !cpu_done;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        led       = led_q;
    end

endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Shares the single-port data memory and the memory-mapped switch/LED registers between the CPU load/store path and the UART program loader. It sits between the CPU datapath (ALU address plus rt store data) and Data_mem. It decodes the IO region, sequences each access through a small state machine and stalls the CPU while the loader owns the bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width of both requesters.
- `DATA_WIDTH`, 32: data width.
- `IO_BASE`, 22'h3FFFFF: value of `addr[31:10]` that selects the IO region.
- `LED_OFS`, 8'h60: `addr[7:0]` offset of the LED register.
- `SW_OFS`, 8'h70: `addr[7:0]` offset of the switch register.

Ports:
- `clk` in 1: the only clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32, `cpu_wdata` in 32: CPU address and store data.
- `cpu_rdata` out 32: load data.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: freezes the PC and pipeline.
- `ldr_req` in 1, `ldr_we` in 1, `ldr_addr` in 32, `ldr_wdata` in 32: loader request.
- `ldr_rdata` out 32, `ldr_done` out 1: loader response.
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: Data_mem port.
- `mem_rdata` in 32: Data_mem read data, synchronous, valid 1 cycle after the address.
- `switch` in 16: board switches.
- `led` out 16: board LEDs, registered.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester is requesting, latch it as owner along with its we/addr/wdata, then go to ACCESS.
  - If both are requesting, the tie-break is set by Configuration.
- ACCESS (exactly 1 cycle):
  - `mem_addr` and `mem_wdata` are driven from the latched request.
  - `is_io` = (`addr[31:10]` == `IO_BASE`).
  - `mem_we` = we && !is_io.
  - IO write to `LED_OFS`: `led` <= wdata[15:0] at the end of the cycle.
  - IO write to any other offset: discarded.
  - Write: owner's done pulses in this cycle, next state IDLE.
  - Read: next state RESP.
  - `switch` is sampled at the end of ACCESS.
- RESP (1 cycle):
  - Owner's rdata is loaded from `mem_rdata` (memory), {16'b0, sampled switch} (`SW_OFS`), or 0 (other IO offsets).
  - The done pulse coincides with rdata being loaded.
  - Next state IDLE.
- `cpu_rdata` and `ldr_rdata` are registers: they hold their value until the next read completes for that requester.
- `cpu_stall` = `cpu_req` && !`cpu_done` (combinational). The loader has no stall; it waits for `ldr_done`.
- Requesters hold req/we/addr/wdata stable until their done. A request dropped after being latched still completes; the done pulse is still issued.
- When not in ACCESS, `mem_we` = 0 and `mem_addr` / `mem_wdata` hold their last values.
- Addresses pass through unchanged. Word alignment is the requester's responsibility.

## Timing
- Reset values: state IDLE, `led` 0, `cpu_rdata` 0, `ldr_rdata` 0, `cpu_done` 0, `ldr_done` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, last_owner = CPU.
- Write with request seen in IDLE at cycle N: `mem_we` and done at N+1. A back-to-back request is arbitrated at N+2.
- Read with request at N: `mem_addr` at N+1, data and done at N+2, IDLE at N+3.
- Done is never asserted in IDLE.
- A requester is never granted twice in consecutive arbitrations while the other is waiting (round-robin build only).
- Reset asserted mid-operation: the access is aborted immediately and asynchronously, with no done pulse. A memory write in progress is suppressed by `mem_we` going to 0. `led` clears.
- A request arriving while the block is busy waits in IDLE arbitration. No request is lost; `cpu_stall` stays high for the whole wait.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: ties are granted to the requester that was not last_owner. last_owner updates on each grant and resets to CPU, so the loader wins the first tie.
  - Undefined: the loader always wins ties (fixed priority). last_owner logic is removed.

## Test plan
- Reset, then CPU store 0x12345678 to 0x00000010: `mem_we` = 1 with `mem_addr` 0x10 one cycle after the request; `cpu_done` in the same cycle; `cpu_stall` high only in the request cycle.
- CPU load from 0x10 with `mem_rdata` = 0xCAFEF00D: `cpu_rdata` = 0xCAFEF00D and `cpu_done` two cycles after the request.
- CPU store 0x0000A5A5 to 0xFFFFFC60: `led` = 16'hA5A5, `mem_we` stays 0. CPU load from 0xFFFFFC70 with `switch` = 16'h00F3: `cpu_rdata` = 0x000000F3.
- `cpu_req` and `ldr_req` held high together for 4 grants:
  - Round-robin build: grant order LDR, CPU, LDR, CPU.
  - Fixed-priority build: LDR, LDR, LDR, LDR, with `cpu_stall` held high.
- Loader read in progress (state RESP), `rst` pulled low: no `ldr_done`, `mem_we` 0, `led` 0. After release, the first access completes with normal latency.
